// File: rtl/mem_store_rmw.sv
// Store path to a word-only data memory. Each SW write goes straight to memory.
// Each SB or SH write reads the word, merges the lane and writes the word back.
// The core is stalled through st_busy until the write commits.
module mem_store_rmw #(
    parameter int ADDR_W    = 32,
    parameter bit SW_DIRECT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [1:0]        st_ctr,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              st_busy,
    output logic              st_done,
    output logic              st_misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

    localparam logic [1:0] CTR_SB  = 2'b00;
    localparam logic [1:0] CTR_SH  = 2'b01;
    localparam logic [1:0] CTR_SW  = 2'b10;
    localparam logic [1:0] CTR_RSV = 2'b11;

    state_t            state_q, state_d;
    logic [1:0]        ctr_q, ctr_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic aligned;
    logic accept;

    // Replace one little-endian lane of the word read from memory with store data
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [1:0]  ctr,
                                               input logic [1:0]  lane,
                                               input logic [31:0] data);
        logic [31:0] r;
        r = word;
        if (ctr == CTR_SB) begin
            case (lane)
                2'd0:    r[7:0]   = data[7:0];
                2'd1:    r[15:8]  = data[7:0];
                2'd2:    r[23:16] = data[7:0];
                default: r[31:24] = data[7:0];
            endcase
        end else if (ctr == CTR_SH) begin
            if (lane[1]) r[31:16] = data[15:0];
            else         r[15:0]  = data[15:0];
        end else begin
            // SW taking the read-modify-write path replaces the whole word
            r = data;
        end
        return r;
    endfunction

    // Request qualification: alignment check and acceptance in IDLE
    always_comb begin
        aligned = 1'b1;
        case (st_ctr)
            CTR_SH:  aligned = ~st_addr[0];
            CTR_SW:  aligned = (st_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        accept      = (state_q == IDLE) && st_valid && (st_ctr != CTR_RSV) && aligned;
        st_misalign = rst_n && (state_q == IDLE) && st_valid && (st_ctr != CTR_RSV) && !aligned;
        st_busy     = rst_n && (accept || (state_q == READ) || (state_q == WAIT));
    end

    // Next-state logic: capture the request, then sequence read, merge and write
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        lane_d  = lane_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ctr_d  = st_ctr;
                    lane_d = st_addr[1:0];
                    data_d = st_data;
                    addr_d = {st_addr[ADDR_W-1:2], 2'b00};
                    if (SW_DIRECT && (st_ctr == CTR_SW)) begin
                        wdata_d = st_data;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:  state_d = WAIT;
            WAIT: begin
                wdata_d = merge_lane(mem_rdata, ctr_q, lane_q, data_q);
                state_d = WRITE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctr_q   <= 2'b00;
            lane_q  <= 2'b00;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Memory strobes decoded from the registered state
    always_comb begin
        mem_rd_en = (state_q == READ);
        mem_wr_en = (state_q == WRITE);
        st_done   = (state_q == WRITE);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_mem_store_rmw.sv
// Directed bench for mem_store_rmw with a small word memory model.
module tb_mem_store_rmw;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [1:0]  st_ctr;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_busy;
    logic        st_done;
    logic        st_misalign;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;

    int checks;
    int failures;

    logic [31:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    mem_store_rmw #(.ADDR_W(32), .SW_DIRECT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ctr(st_ctr),
        .st_addr(st_addr), .st_data(st_data), .st_busy(st_busy),
        .st_done(st_done), .st_misalign(st_misalign), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: one-cycle read latency, write at the strobe edge, bench preload port
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr[7:2]];
        if (mem_wr_en) mem[mem_addr[7:2]] <= mem_wdata;
        if (pl_en)     mem[pl_idx] <= pl_val;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Issue one store, watch up to 7 cycles; exp_rd = -1 when no read is expected
    task automatic do_store(input string tag, input logic [1:0] ctr, input logic [31:0] addr,
                            input logic [31:0] data, input int exp_rd, input int exp_wr,
                            input logic [31:0] exp_wdata);
        int rd_cyc, wr_cyc, rd_cnt, wr_cnt;
        rd_cyc = -1; wr_cyc = -1; rd_cnt = 0; wr_cnt = 0;
        @(posedge clk); #1;
        st_valid = 1'b1; st_ctr = ctr; st_addr = addr; st_data = data;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check({tag, " busy"}, {31'd0, st_busy}, {31'd0, (c < exp_wr)});
            if (mem_rd_en) begin
                rd_cnt++; rd_cyc = c;
                check({tag, " rd_addr"}, mem_addr, {addr[31:2], 2'b00});
            end
            if (mem_wr_en) begin
                wr_cnt++; wr_cyc = c;
                check({tag, " wdata"}, mem_wdata, exp_wdata);
                check({tag, " wr_addr"}, mem_addr, {addr[31:2], 2'b00});
                check({tag, " done"}, {31'd0, st_done}, 32'd1);
            end
            @(posedge clk); #1;
            if (c == exp_wr) st_valid = 1'b0;
        end
        check({tag, " rd_cycle"}, rd_cyc, exp_rd);
        check({tag, " rd_count"}, rd_cnt, (exp_rd < 0) ? 0 : 1);
        check({tag, " wr_cycle"}, wr_cyc, exp_wr);
        check({tag, " wr_count"}, wr_cnt, 1);
        check({tag, " mem"}, mem[addr[7:2]], exp_wdata);
    endtask

    // Present a rejected request for a few cycles and confirm nothing happens
    task automatic do_reject(input string tag, input logic [1:0] ctr, input logic [31:0] addr,
                             input logic exp_mis);
        int strobes;
        strobes = 0;
        @(posedge clk); #1;
        st_valid = 1'b1; st_ctr = ctr; st_addr = addr; st_data = 32'h5A5A5A5A;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check({tag, " misalign"}, {31'd0, st_misalign}, {31'd0, exp_mis});
            check({tag, " busy"}, {31'd0, st_busy}, 32'd0);
            if (mem_rd_en || mem_wr_en) strobes++;
            @(posedge clk); #1;
        end
        st_valid = 1'b0;
        check({tag, " strobes"}, strobes, 0);
    endtask

    initial begin
        int wr_cnt, first_wr, second_wr, late_wr;
        checks = 0; failures = 0;
        rst_n = 1'b0; st_valid = 1'b0; st_ctr = 2'b00; st_addr = '0; st_data = '0;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", {31'd0, st_busy}, 32'd0);
        check("rst rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("rst wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst addr", mem_addr, 32'd0);
        check("rst wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // SW direct
        do_store("sw10", 2'b10, 32'h10, 32'hDEADBEEF, -1, 1, 32'hDEADBEEF);

        // SB lane 3
        preload(6'd4, 32'h11223344);
        do_store("sb13", 2'b00, 32'h13, 32'h000000AA, 1, 3, 32'hAA223344);

        // SB lane 1
        preload(6'd12, 32'hAABBCCDD);
        do_store("sb31", 2'b00, 32'h31, 32'hFFFFFF55, 1, 3, 32'hAABB55DD);

        // SH upper and lower halves
        preload(6'd8, 32'h11223344);
        do_store("sh22", 2'b01, 32'h22, 32'h1234BEEF, 1, 3, 32'hBEEF3344);
        preload(6'd8, 32'h11223344);
        do_store("sh20", 2'b01, 32'h20, 32'h1234BEEF, 1, 3, 32'h1122BEEF);

        // Rejected requests
        do_reject("sh21", 2'b01, 32'h21, 1'b1);
        do_reject("sw12", 2'b10, 32'h12, 1'b1);
        do_reject("rsv", 2'b11, 32'h10, 1'b0);

        // Reset during WAIT of an SB drops the write
        late_wr = 0;
        @(posedge clk); #1;
        st_valid = 1'b1; st_ctr = 2'b00; st_addr = 32'h13; st_data = 32'h00000077;
        @(posedge clk); #1;
        if (mem_wr_en) late_wr++;
        @(posedge clk); #1;
        rst_n = 1'b0; st_valid = 1'b0;
        @(negedge clk);
        check("rstwait busy", {31'd0, st_busy}, 32'd0);
        check("rstwait misalign", {31'd0, st_misalign}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstwait rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("rstwait done", {31'd0, st_done}, 32'd0);
        check("rstwait addr", mem_addr, 32'd0);
        check("rstwait wdata", mem_wdata, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_wr_en) late_wr++;
            if (c == 1) begin
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        end
        check("rstwait wr_pulses", late_wr, 0);
        check("rstwait mem", mem[4], 32'hAA223344);

        // Back-to-back SB then SW with st_valid held high
        preload(6'd0, 32'h11223344);
        preload(6'd1, 32'h00000000);
        wr_cnt = 0; first_wr = -1; second_wr = -1;
        @(posedge clk); #1;
        st_valid = 1'b1; st_ctr = 2'b00; st_addr = 32'h03; st_data = 32'h000000CC;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (mem_wr_en) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = c;
                else second_wr = c;
            end
            @(posedge clk); #1;
            if (c == 3) begin
                check("b2b mem0", mem[0], 32'hCC223344);
                st_ctr = 2'b10; st_addr = 32'h04; st_data = 32'hCAFEF00D;
            end
            if (c == 5) begin
                check("b2b mem1", mem[1], 32'hCAFEF00D);
                st_valid = 1'b0;
            end
        end
        check("b2b wr_count", wr_cnt, 2);
        check("b2b first_wr", first_wr, 3);
        check("b2b second_wr", second_wr, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
